mem_access_unit: RTL and testbench

- Initiator side of the MIPS data-memory interface; sits in the MEM stage between the pipeline and the word-addressed data memory.
- Accepts byte-addressed load/store requests and drives the memory's word address, write data and write enable.
- Performs sub-word extraction and sign/zero extension on loads, and read-modify-write for SB/SH.
- Detects misaligned or out-of-range accesses and raises MIPS AdEL/AdES.

---
 rtl/mips_mem_pkg.sv | 36 +++
 rtl/mem_access_unit_load_extend.sv | 31 +++
 rtl/mem_access_unit.sv | 131 +++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory access path: op codes,
// access-unit FSM states and lane geometry.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b011,
    OP_LHU = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } mem_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RMW_WR
  } mau_state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  function automatic logic op_is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_half(input mem_op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic op_is_word(input mem_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Little-endian sub-word select and sign/zero extension of a memory word
// for loads; store ops produce zero.
module load_extend
  import mips_mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] Mem_RD,
  input  logic [1:0]       Offset,
  input  mem_op_e          Op,
  output logic [WIDTH-1:0] RData
);

  logic [BYTE_W-1:0] sel_byte;
  logic [HALF_W-1:0] sel_half;

  always_comb begin
    sel_byte = Mem_RD[int'(Offset) * BYTE_W +: BYTE_W];
    sel_half = Mem_RD[int'(Offset[1]) * HALF_W +: HALF_W];
    RData    = '0;
    unique case (Op)
      OP_LB:   RData = {{(WIDTH-BYTE_W){sel_byte[BYTE_W-1]}}, sel_byte};
      OP_LBU:  RData = {{(WIDTH-BYTE_W){1'b0}}, sel_byte};
      OP_LH:   RData = {{(WIDTH-HALF_W){sel_half[HALF_W-1]}}, sel_half};
      OP_LHU:  RData = {{(WIDTH-HALF_W){1'b0}}, sel_half};
      OP_LW:   RData = Mem_RD;
      default: RData = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-addressed data memory: loads, stores,
// SB/SH read-modify-write and AdEL/AdES address-error detection.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 100
) (
  input  logic             MemAccess_CLK,
  input  logic             MemAccess_RST,
  input  logic             MemAccess_Req,
  input  logic [2:0]       MemAccess_Op,
  input  logic [WIDTH-1:0] MemAccess_Addr,
  input  logic [WIDTH-1:0] MemAccess_WData,
  output logic [WIDTH-1:0] MemAccess_RData,
  output logic             MemAccess_Stall,
  output logic             MemAccess_AdEL,
  output logic             MemAccess_AdES,
  output logic [WIDTH-1:0] MemAccess_BadVAddr,
  output logic [WIDTH-1:0] Mem_A,
  output logic [WIDTH-1:0] Mem_WD,
  output logic             Mem_WE,
  input  logic [WIDTH-1:0] Mem_RD
);

  mau_state_e state, state_nxt;

  mem_op_e          op;
  logic [WIDTH-1:0] word_idx;
  logic [1:0]       offset;
  logic             misaligned;
  logic             out_of_range;
  logic             fault;
  logic             capture;
  logic [WIDTH-1:0] ext_data;
  logic [WIDTH-1:0] merged;

  mem_op_e          cap_op;
  logic [WIDTH-1:0] cap_word;
  logic [WIDTH-1:0] cap_idx;
  logic [1:0]       cap_off;
  logic [HALF_W-1:0] cap_wdata;

  assign op           = mem_op_e'(MemAccess_Op);
  assign word_idx     = {2'b00, MemAccess_Addr[WIDTH-1:2]};
  assign offset       = MemAccess_Addr[1:0];
  assign misaligned   = (op_is_half(op) && offset[0]) || (op_is_word(op) && (offset != 2'b00));
  assign out_of_range = word_idx >= WIDTH'(DEPTH);
  assign fault        = MemAccess_Req && (state == ST_IDLE) && (misaligned || out_of_range);

  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .Mem_RD (Mem_RD),
    .Offset (offset),
    .Op     (op),
    .RData  (ext_data)
  );

  // Replace only the targeted lane(s) of the word read in the capture cycle.
  always_comb begin
    merged = cap_word;
    if (cap_op == OP_SH)
      merged[int'(cap_off[1]) * HALF_W +: HALF_W] = cap_wdata;
    else
      merged[int'(cap_off) * BYTE_W +: BYTE_W] = cap_wdata[BYTE_W-1:0];
  end

  always_comb begin
    state_nxt       = state;
    Mem_A           = '0;
    Mem_WD          = '0;
    Mem_WE          = 1'b0;
    MemAccess_Stall = 1'b0;
    MemAccess_AdEL  = 1'b0;
    MemAccess_AdES  = 1'b0;
    MemAccess_RData = '0;
    capture         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fault) begin
          MemAccess_AdES = op_is_store(op);
          MemAccess_AdEL = !op_is_store(op);
        end else if (MemAccess_Req) begin
          Mem_A = word_idx;
          unique case (op)
            OP_SW: begin
              Mem_WE = 1'b1;
              Mem_WD = MemAccess_WData;
            end
            OP_SB, OP_SH: begin
              MemAccess_Stall = 1'b1;
              capture         = 1'b1;
              state_nxt       = ST_RMW_WR;
            end
            default: MemAccess_RData = ext_data;
          endcase
        end
      end
      ST_RMW_WR: begin
        Mem_A     = cap_idx;
        Mem_WE    = 1'b1;
        Mem_WD    = merged;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge MemAccess_CLK or negedge MemAccess_RST) begin
    if (!MemAccess_RST) begin
      state              <= ST_IDLE;
      cap_op             <= OP_LB;
      cap_word           <= '0;
      cap_idx            <= '0;
      cap_off            <= '0;
      cap_wdata          <= '0;
      MemAccess_BadVAddr <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cap_op    <= op;
        cap_word  <= Mem_RD;
        cap_idx   <= word_idx;
        cap_off   <= offset;
        cap_wdata <= MemAccess_WData[HALF_W-1:0];
      end
      if (fault)
        MemAccess_BadVAddr <= MemAccess_Addr;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed checks of mem_access_unit against a behavioural 100-word memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, badv, mem_a, mem_wd, mem_rd;
  logic        stall, adel, ades, mem_we;

  logic [31:0] mem [0:99];
  int unsigned compared = 0;
  int unsigned mismatched = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011,
                         LHU = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  always #5 clk = ~clk;

  mem_access_unit #(.WIDTH(32), .DEPTH(100)) dut (
    .MemAccess_CLK      (clk),
    .MemAccess_RST      (rst_n),
    .MemAccess_Req      (req),
    .MemAccess_Op       (op),
    .MemAccess_Addr     (addr),
    .MemAccess_WData    (wdata),
    .MemAccess_RData    (rdata),
    .MemAccess_Stall    (stall),
    .MemAccess_AdEL     (adel),
    .MemAccess_AdES     (ades),
    .MemAccess_BadVAddr (badv),
    .Mem_A              (mem_a),
    .Mem_WD             (mem_wd),
    .Mem_WE             (mem_we),
    .Mem_RD             (mem_rd)
  );

  always_comb mem_rd = (mem_a < 32'd100) ? mem[mem_a[6:0]] : '0;

  always @(posedge clk)
    if (mem_we && mem_a < 32'd100) mem[mem_a[6:0]] <= mem_wd;

  task automatic drive(input logic r, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    req = r; op = o; addr = a; wdata = d;
    #3;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL rst_stall: got %b want 0", stall); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL rst_we: got %b want 0", mem_we); end
    compared++; if ({adel, ades} !== 2'b00) begin mismatched++; $display("FAIL rst_ad: got %b want 00", {adel, ades}); end
    compared++; if (rdata !== 32'h0) begin mismatched++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    compared++; if (badv !== 32'h0) begin mismatched++; $display("FAIL rst_badv: got %h want 0", badv); end
    compared++; if ({mem_a, mem_wd} !== 64'h0) begin mismatched++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", mem_a, mem_wd); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_store_word();
    drive(1'b1, SW, 32'h0C, 32'h80F0_1234); next_cycle();
    drive(1'b1, SW, 32'h10, 32'h0); next_cycle();
    drive(1'b1, SW, 32'h14, 32'h1122_3344); next_cycle();
    drive(1'b1, SW, 32'h08, 32'hDEAD_BEEF);
    compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL sw_we: got %b want 1", mem_we); end
    compared++; if (mem_wd !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL sw_wd: got %h want deadbeef", mem_wd); end
    compared++; if (mem_a !== 32'd2) begin mismatched++; $display("FAIL sw_a: got %h want 2", mem_a); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL sw_stall: got %b want 0", stall); end
    next_cycle();
    drive(1'b0, LB, 32'h0, 32'h0);
    compared++; if (mem[2] !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL sw_word2: got %h want deadbeef", mem[2]); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL sw_stall_after: got %b want 0", stall); end
  endtask

  task automatic test_load();
    drive(1'b1, LB, 32'h0E, 32'h0);
    compared++; if (rdata !== 32'hFFFF_FFF0) begin mismatched++; $display("FAIL lb: got %h want fffffff0", rdata); end
    compared++; if (mem_a !== 32'd3) begin mismatched++; $display("FAIL lb_a: got %h want 3", mem_a); end
    next_cycle();
    drive(1'b1, LBU, 32'h0E, 32'h0);
    compared++; if (rdata !== 32'h0000_00F0) begin mismatched++; $display("FAIL lbu: got %h want 000000f0", rdata); end
    next_cycle();
    drive(1'b1, LH, 32'h0E, 32'h0);
    compared++; if (rdata !== 32'hFFFF_80F0) begin mismatched++; $display("FAIL lh: got %h want ffff80f0", rdata); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL lh_stall: got %b want 0", stall); end
    next_cycle();
    drive(1'b1, LHU, 32'h0C, 32'h0);
    compared++; if (rdata !== 32'h0000_1234) begin mismatched++; $display("FAIL lhu: got %h want 00001234", rdata); end
    next_cycle();
    drive(1'b1, LB, 32'h0D, 32'h0);
    compared++; if (rdata !== 32'h0000_0012) begin mismatched++; $display("FAIL lb_pos: got %h want 00000012", rdata); end
    next_cycle();
    drive(1'b1, LW, 32'h0C, 32'h0);
    compared++; if (rdata !== 32'h80F0_1234) begin mismatched++; $display("FAIL lw: got %h want 80f01234", rdata); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL lw_we: got %b want 0", mem_we); end
    next_cycle();
    drive(1'b0, LW, 32'h0C, 32'h0);
    compared++; if (rdata !== 32'h0) begin mismatched++; $display("FAIL idle_rdata: got %h want 0", rdata); end
  endtask

  task automatic test_rmw();
    drive(1'b1, SB, 32'h09, 32'hFFFF_FF55);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL sb_stall: got %b want 1", stall); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL sb_we0: got %b want 0", mem_we); end
    next_cycle();
    drive(1'b0, SW, 32'h40, 32'hCAFE_F00D);
    compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL sb_we1: got %b want 1", mem_we); end
    compared++; if (mem_wd !== 32'hDEAD_55EF) begin mismatched++; $display("FAIL sb_wd: got %h want dead55ef", mem_wd); end
    compared++; if (mem_a !== 32'd2) begin mismatched++; $display("FAIL sb_a: got %h want 2", mem_a); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL sb_stall1: got %b want 0", stall); end
    next_cycle();
    drive(1'b1, SH, 32'h0A, 32'hABCD_1234);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL sh_stall: got %b want 1", stall); end
    next_cycle();
    drive(1'b1, LW, 32'h00, 32'h0);
    compared++; if (mem_wd !== 32'h1234_55EF) begin mismatched++; $display("FAIL sh_wd: got %h want 123455ef", mem_wd); end
    next_cycle();
    drive(1'b0, LW, 32'h0, 32'h0);
    compared++; if (mem[2] !== 32'h1234_55EF) begin mismatched++; $display("FAIL sh_word2: got %h want 123455ef", mem[2]); end
  endtask

  task automatic test_faults();
    drive(1'b1, LW, 32'h06, 32'h0);
    compared++; if ({adel, ades} !== 2'b10) begin mismatched++; $display("FAIL lw_mis_ad: got %b want 10", {adel, ades}); end
    compared++; if ({mem_we, stall} !== 2'b00) begin mismatched++; $display("FAIL lw_mis_we_stall: got %b want 00", {mem_we, stall}); end
    compared++; if (rdata !== 32'h0) begin mismatched++; $display("FAIL lw_mis_rdata: got %h want 0", rdata); end
    next_cycle();
    drive(1'b0, LW, 32'h0, 32'h0);
    compared++; if (badv !== 32'h06) begin mismatched++; $display("FAIL badv_06: got %h want 6", badv); end
    next_cycle();
    drive(1'b1, SH, 32'h0B, 32'h1111);
    compared++; if ({adel, ades} !== 2'b01) begin mismatched++; $display("FAIL sh_mis_ad: got %b want 01", {adel, ades}); end
    compared++; if ({mem_we, stall} !== 2'b00) begin mismatched++; $display("FAIL sh_mis_we_stall: got %b want 00", {mem_we, stall}); end
    next_cycle();
    drive(1'b1, SW, 32'h190, 32'h5555_5555);
    compared++; if ({adel, ades, mem_we} !== 3'b010) begin mismatched++; $display("FAIL sw_oor: got %b want 010", {adel, ades, mem_we}); end
    next_cycle();
    drive(1'b1, LW, 32'h190, 32'h0);
    compared++; if (adel !== 1'b1) begin mismatched++; $display("FAIL lw_oor_adel: got %b want 1", adel); end
    next_cycle();
    drive(1'b1, LW, 32'h18C, 32'h0);
    compared++; if ({adel, ades} !== 2'b00) begin mismatched++; $display("FAIL lw_last_word: got %b want 00", {adel, ades}); end
    compared++; if (badv !== 32'h190) begin mismatched++; $display("FAIL badv_190: got %h want 190", badv); end
    next_cycle();
    drive(1'b1, LW, 32'h0C, 32'h0);
    next_cycle();
    drive(1'b0, LW, 32'h0, 32'h0);
    compared++; if (badv !== 32'h190) begin mismatched++; $display("FAIL badv_hold: got %h want 190", badv); end
  endtask

  task automatic test_reset_in_rmw();
    drive(1'b1, SB, 32'h14, 32'hAA);
    next_cycle();
    drive(1'b0, LB, 32'h0, 32'h0);
    compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL rrmw_we_pre: got %b want 1", mem_we); end
    rst_n = 1'b0;
    #1;
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL rrmw_we: got %b want 0", mem_we); end
    compared++; if ({stall, adel, ades} !== 3'b000) begin mismatched++; $display("FAIL rrmw_flags: got %b want 000", {stall, adel, ades}); end
    compared++; if ({mem_a, mem_wd} !== 64'h0) begin mismatched++; $display("FAIL rrmw_bus: got %h/%h want 0/0", mem_a, mem_wd); end
    compared++; if (badv !== 32'h0) begin mismatched++; $display("FAIL rrmw_badv: got %h want 0", badv); end
    next_cycle();
    compared++; if (mem[5] !== 32'h1122_3344) begin mismatched++; $display("FAIL rrmw_word5: got %h want 11223344", mem[5]); end
    rst_n = 1'b1;
    next_cycle();
    drive(1'b1, LW, 32'h14, 32'h0);
    compared++; if ({stall, mem_we, rdata} !== {2'b00, 32'h1122_3344}) begin mismatched++; $display("FAIL rrmw_idle: got %b%b %h want 00 11223344", stall, mem_we, rdata); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, SB, 32'h10, 32'hA1);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL b2b_stall0: got %b want 1", stall); end
    next_cycle();
    drive(1'b0, SB, 32'h11, 32'hB2);
    compared++; if (mem_wd !== 32'h0000_00A1) begin mismatched++; $display("FAIL b2b_wd0: got %h want 000000a1", mem_wd); end
    next_cycle();
    drive(1'b1, SB, 32'h11, 32'hB2);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL b2b_stall1: got %b want 1", stall); end
    next_cycle();
    drive(1'b0, LB, 32'h0, 32'h0);
    compared++; if (mem_wd !== 32'h0000_B2A1) begin mismatched++; $display("FAIL b2b_wd1: got %h want 0000b2a1", mem_wd); end
    next_cycle();
    compared++; if (mem[4] !== 32'h0000_B2A1) begin mismatched++; $display("FAIL b2b_word4: got %h want 0000b2a1", mem[4]); end
  endtask

  always @(negedge clk)
    if (rst_n && mem_we && (adel || ades)) begin
      mismatched++;
      $display("FAIL we_with_ade: got we=%b adel=%b ades=%b want we=0", mem_we, adel, ades);
    end

  initial begin
    test_reset();
    test_store_word();
    test_load();
    test_rmw();
    test_faults();
    test_reset_in_rmw();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
